// File: rtl/mem_bus_master.sv
// Bus initiator for the shared peripheral memory bus.
// Takes one load/store request at a time over a valid/ready handshake and runs
// one fixed-length bus cycle of WAIT_CYCLES+1 strobe cycles for it. Misaligned
// requests return an error without touching the bus.
//
// Ports:
//   clock, reset                    system clock, synchronous active-high reset
//   req_valid/req_ready             request handshake (ready only in IDLE)
//   req_write/addr/size/signed      request attributes
//   req_wdata                       store data, low size bits used
//   resp_valid                      one-cycle completion pulse
//   resp_rdata/resp_error           extended load data / misalignment flag
//   address/size/mem_read/mem_write bus address, size and strobes
//   data                            bidirectional bus data, driven only while mem_write
module mem_bus_master #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned ADDR_WIDTH  = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [63:0]           req_wdata,
    output logic                  resp_valid,
    output logic [63:0]           resp_rdata,
    output logic                  resp_error,
    output logic [ADDR_WIDTH-1:0] address,
    inout  wire  [63:0]           data,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [1:0]            size
);

    localparam int unsigned DATA_W = 64;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t                state, state_next;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic                  lat_signed, lat_signed_next;
    logic [DATA_W-1:0]     data_out, data_out_next;
    logic                  req_ready_next;
    logic                  resp_valid_next;
    logic                  resp_error_next;
    logic [DATA_W-1:0]     resp_rdata_next;
    logic [ADDR_WIDTH-1:0] address_next;
    logic [1:0]            size_next;
    logic                  mem_read_next;
    logic                  mem_write_next;

    // Natural alignment: the low log2(bytes) address bits must be zero.
    function automatic logic misaligned(input logic [2:0] a, input logic [1:0] sz);
        case (sz)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = a[0];
            2'b10:   misaligned = |a[1:0];
            default: misaligned = |a;
        endcase
    endfunction

    // Keep only the bytes covered by the access size.
    function automatic logic [DATA_W-1:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   size_mask = 64'h0000_0000_0000_00FF;
            2'b01:   size_mask = 64'h0000_0000_0000_FFFF;
            2'b10:   size_mask = 64'h0000_0000_FFFF_FFFF;
            default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    // Truncate to size, then zero- or sign-extend from the size MSB.
    function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] raw,
                                                 input logic [1:0] sz,
                                                 input logic sgn);
        case (sz)
            2'b00:   extend = {{56{sgn & raw[7]}},  raw[7:0]};
            2'b01:   extend = {{48{sgn & raw[15]}}, raw[15:0]};
            2'b10:   extend = {{32{sgn & raw[31]}}, raw[31:0]};
            default: extend = raw;
        endcase
    endfunction

    // The bus is only ever driven while the write strobe is up.
    assign data = mem_write ? data_out : {DATA_W{1'bz}};

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_signed <= 1'b0;
            data_out   <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_rdata <= '0;
            address    <= '0;
            size       <= 2'b00;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            lat_signed <= lat_signed_next;
            data_out   <= data_out_next;
            req_ready  <= req_ready_next;
            resp_valid <= resp_valid_next;
            resp_error <= resp_error_next;
            resp_rdata <= resp_rdata_next;
            address    <= address_next;
            size       <= size_next;
            mem_read   <= mem_read_next;
            mem_write  <= mem_write_next;
        end
    end

    // Next-state and next-output logic; address/size registers double as the request latches.
    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        lat_signed_next = lat_signed;
        data_out_next   = data_out;
        req_ready_next  = req_ready;
        resp_valid_next = 1'b0;
        resp_error_next = resp_error;
        resp_rdata_next = resp_rdata;
        address_next    = address;
        size_next       = size;
        mem_read_next   = mem_read;
        mem_write_next  = mem_write;

        case (state)
            IDLE: begin
                req_ready_next = 1'b1;
                if (req_valid) begin
                    req_ready_next = 1'b0;
                    if (misaligned(req_addr[2:0], req_size)) begin
                        state_next      = RESP;
                        resp_valid_next = 1'b1;
                        resp_error_next = 1'b1;
                        resp_rdata_next = '0;
                    end else begin
                        state_next      = ACCESS;
                        cnt_next        = CNT_W'(WAIT_CYCLES);
                        address_next    = req_addr;
                        size_next       = req_size;
                        lat_signed_next = req_signed;
                        mem_write_next  = req_write;
                        mem_read_next   = ~req_write;
                        data_out_next   = req_write ? (req_wdata & size_mask(req_size)) : '0;
                    end
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    // Last strobe cycle: loads capture the bus on this edge.
                    state_next      = RESP;
                    resp_valid_next = 1'b1;
                    resp_error_next = 1'b0;
                    resp_rdata_next = mem_read ? extend(data, size, lat_signed) : '0;
                    mem_read_next   = 1'b0;
                    mem_write_next  = 1'b0;
                    address_next    = '0;
                    size_next       = 2'b00;
                    data_out_next   = '0;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            RESP: begin
                state_next     = IDLE;
                req_ready_next = 1'b1;
            end
            default: begin
                state_next     = IDLE;
                req_ready_next = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench for mem_bus_master: three instances (WAIT_CYCLES 1, 3, 0)
// share request inputs; only the selected one sees req_valid.
module tb_mem_bus_master;

    localparam int unsigned AW = 32;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset;
    logic          req_valid;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [1:0]    req_size;
    logic          req_signed;
    logic [63:0]   req_wdata;
    int            sel;

    logic          vld0, vld1, vld2;
    logic          rdy_o [3];
    logic          rv_o  [3];
    logic          re_o  [3];
    logic [63:0]   rd_o  [3];
    logic [AW-1:0] ad_o  [3];
    logic          mr_o  [3];
    logic          mw_o  [3];
    logic [1:0]    sz_o  [3];
    wire  [63:0]   d0, d1, d2;

    logic [63:0]   rsp_data;
    logic [63:0]   idle_pat;

    int total  = 0;
    int passed = 0;

    assign vld0 = req_valid && (sel == 0);
    assign vld1 = req_valid && (sel == 1);
    assign vld2 = req_valid && (sel == 2);

    // Responder: returns rsp_data during reads, parks a pattern otherwise, releases during writes.
    assign d0 = mw_o[0] ? 64'bz : (mr_o[0] ? rsp_data : idle_pat);
    assign d1 = mw_o[1] ? 64'bz : (mr_o[1] ? rsp_data : idle_pat);
    assign d2 = mw_o[2] ? 64'bz : (mr_o[2] ? rsp_data : idle_pat);

    mem_bus_master #(.WAIT_CYCLES(1), .ADDR_WIDTH(AW)) dut0 (
        .clock(clock), .reset(reset), .req_valid(vld0), .req_ready(rdy_o[0]),
        .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
        .req_signed(req_signed), .req_wdata(req_wdata), .resp_valid(rv_o[0]),
        .resp_rdata(rd_o[0]), .resp_error(re_o[0]), .address(ad_o[0]), .data(d0),
        .mem_read(mr_o[0]), .mem_write(mw_o[0]), .size(sz_o[0]));

    mem_bus_master #(.WAIT_CYCLES(3), .ADDR_WIDTH(AW)) dut1 (
        .clock(clock), .reset(reset), .req_valid(vld1), .req_ready(rdy_o[1]),
        .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
        .req_signed(req_signed), .req_wdata(req_wdata), .resp_valid(rv_o[1]),
        .resp_rdata(rd_o[1]), .resp_error(re_o[1]), .address(ad_o[1]), .data(d1),
        .mem_read(mr_o[1]), .mem_write(mw_o[1]), .size(sz_o[1]));

    mem_bus_master #(.WAIT_CYCLES(0), .ADDR_WIDTH(AW)) dut2 (
        .clock(clock), .reset(reset), .req_valid(vld2), .req_ready(rdy_o[2]),
        .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
        .req_signed(req_signed), .req_wdata(req_wdata), .resp_valid(rv_o[2]),
        .resp_rdata(rd_o[2]), .resp_error(re_o[2]), .address(ad_o[2]), .data(d2),
        .mem_read(mr_o[2]), .mem_write(mw_o[2]), .size(sz_o[2]));

    logic          c_rdy, c_rv, c_re, c_mr, c_mw;
    logic [63:0]   c_rd, c_data;
    logic [AW-1:0] c_ad;
    logic [1:0]    c_sz;

    // View of the currently selected instance.
    always_comb begin
        c_rdy = rdy_o[0]; c_rv = rv_o[0]; c_re = re_o[0]; c_rd = rd_o[0];
        c_ad = ad_o[0]; c_mr = mr_o[0]; c_mw = mw_o[0]; c_sz = sz_o[0]; c_data = d0;
        if (sel == 1) begin
            c_rdy = rdy_o[1]; c_rv = rv_o[1]; c_re = re_o[1]; c_rd = rd_o[1];
            c_ad = ad_o[1]; c_mr = mr_o[1]; c_mw = mw_o[1]; c_sz = sz_o[1]; c_data = d1;
        end else if (sel == 2) begin
            c_rdy = rdy_o[2]; c_rv = rv_o[2]; c_re = re_o[2]; c_rd = rd_o[2];
            c_ad = ad_o[2]; c_mr = mr_o[2]; c_mw = mw_o[2]; c_sz = sz_o[2]; c_data = d2;
        end
    end

    // ---------------- reference model ----------------
    function automatic int wait_of(input int s);
        return (s == 0) ? 1 : (s == 1) ? 3 : 0;
    endfunction

    function automatic logic exp_misaligned(input logic [AW-1:0] a, input logic [1:0] sz);
        int unsigned bytes;
        bytes = 1 << sz;
        return (a % bytes) != 0;
    endfunction

    function automatic logic [63:0] exp_trunc(input logic [63:0] v, input logic [1:0] sz);
        int unsigned bits;
        bits = 8 << sz;
        if (bits == 64) return v;
        return v & ((64'd1 << bits) - 64'd1);
    endfunction

    function automatic logic [63:0] exp_load(input logic [63:0] raw, input logic [1:0] sz,
                                             input logic sg);
        int unsigned bits;
        logic [63:0] v;
        bits = 8 << sz;
        v = exp_trunc(raw, sz);
        if (sg && bits < 64 && raw[bits-1]) v = v | ~((64'd1 << bits) - 64'd1);
        return v;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            total++;
            if ({c_rdy, c_rv, c_re, c_rd, c_ad, c_sz, c_mr, c_mw, c_data} !==
                {1'b1, 1'b0, 1'b0, 64'd0, {AW{1'b0}}, 2'b00, 1'b0, 1'b0, idle_pat}) begin
                $display("FAIL reset_state dut%0d: rdy=%b rv=%b re=%b rd=%h ad=%h sz=%b mr=%b mw=%b data=%h",
                         s, c_rdy, c_rv, c_re, c_rd, c_ad, c_sz, c_mr, c_mw, c_data);
            end else passed++;
        end
    endtask

    // One request on the selected instance, checked cycle by cycle against the model.
    task automatic run_txn(input logic wr, input logic [AW-1:0] a, input logic [1:0] sz,
                           input logic sg, input logic [63:0] wd, input logic [63:0] rd);
        int n, exp_strobes, exp_resp, strobes, resp_at;
        logic err;
        logic [63:0] exp_rd;
        n           = wait_of(sel) + 1;
        err         = exp_misaligned(a, sz);
        exp_strobes = err ? 0 : n;
        exp_resp    = err ? 1 : n + 1;
        exp_rd      = (err || wr) ? 64'd0 : exp_load(rd, sz, sg);

        @(posedge clock); #1;
        rsp_data  = rd;
        idle_pat  = {$urandom, $urandom};
        req_write = wr; req_addr = a; req_size = sz; req_signed = sg; req_wdata = wd;
        req_valid = 1'b1;
        @(negedge clock);
        total++;
        if (c_rdy !== 1'b1) $display("FAIL ready_idle: got %b want 1", c_rdy);
        else passed++;
        @(posedge clock); #1;
        // Scramble the request inputs so only latched values can produce the expected bus.
        req_valid = 1'b0;
        req_write = ~wr; req_addr = $urandom; req_size = 2'($urandom);
        req_signed = ~sg; req_wdata = {$urandom, $urandom};

        strobes = 0;
        resp_at = 0;
        for (int c = 1; c <= 40 && resp_at == 0; c++) begin
            @(negedge clock);
            total++;
            if (c_mr && c_mw) $display("FAIL strobe_overlap: mr=%b mw=%b", c_mr, c_mw);
            else passed++;
            if (c_mr || c_mw) begin
                strobes++;
                total++;
                if ({c_mw, c_ad, c_sz} !== {wr, a, sz})
                    $display("FAIL bus_attr: mw=%b ad=%h sz=%b want mw=%b ad=%h sz=%b",
                             c_mw, c_ad, c_sz, wr, a, sz);
                else passed++;
            end
            total++;
            if (c_mw) begin
                if (c_data !== exp_trunc(wd, sz))
                    $display("FAIL store_data: got %h want %h", c_data, exp_trunc(wd, sz));
                else passed++;
            end else begin
                if (c_data !== (c_mr ? rd : idle_pat))
                    $display("FAIL bus_released: got %h want %h", c_data, c_mr ? rd : idle_pat);
                else passed++;
            end
            total++;
            if (c_rv) begin
                resp_at = c;
                if ({resp_at, strobes, c_re, c_rd, c_rdy, c_ad, c_sz} !==
                    {exp_resp, exp_strobes, err, exp_rd, 1'b0, {AW{1'b0}}, 2'b00})
                    $display("FAIL response: cyc=%0d strobes=%0d err=%b rd=%h rdy=%b ad=%h sz=%b want cyc=%0d strobes=%0d err=%b rd=%h",
                             resp_at, strobes, c_re, c_rd, c_rdy, c_ad, c_sz,
                             exp_resp, exp_strobes, err, exp_rd);
                else passed++;
            end else begin
                if (c_rdy !== 1'b0) $display("FAIL ready_busy: cyc=%0d got %b want 0", c, c_rdy);
                else passed++;
            end
        end
        if (resp_at == 0) begin
            total++;
            $display("FAIL resp_timeout: no resp_valid within 40 cycles");
        end
        @(negedge clock);
        total++;
        if ({c_rv, c_rdy, c_re, c_rd} !== {1'b0, 1'b1, err, exp_rd})
            $display("FAIL resp_after: rv=%b rdy=%b re=%b rd=%h want rv=0 rdy=1 re=%b rd=%h",
                     c_rv, c_rdy, c_re, c_rd, err, exp_rd);
        else passed++;
    endtask

    task automatic test_store_basic();
        sel = 0;
        run_txn(1'b1, 32'h08, 2'b11, 1'b0, 64'h0000_0000_0000_A5A5, 64'd0);
        run_txn(1'b1, 32'h0C, 2'b01, 1'b0, 64'h1122_3344_5566_7788, 64'd0);
    endtask

    task automatic test_load_extend();
        sel = 0;
        run_txn(1'b0, 32'h20, 2'b00, 1'b1, 64'd0, 64'h0000_0000_0000_0080);
        run_txn(1'b0, 32'h20, 2'b00, 1'b0, 64'd0, 64'h0000_0000_0000_0080);
        run_txn(1'b0, 32'h22, 2'b01, 1'b1, 64'd0, 64'hFFFF_0000_0000_8001);
    endtask

    task automatic test_misaligned();
        sel = 0;
        run_txn(1'b0, 32'h13, 2'b01, 1'b0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        run_txn(1'b1, 32'h1C, 2'b11, 1'b0, 64'hDEAD, 64'd0);
    endtask

    task automatic test_wait0();
        sel = 2;
        run_txn(1'b0, 32'h40, 2'b10, 1'b1, 64'd0, 64'h1234_5678_8000_0000);
        run_txn(1'b1, 32'h44, 2'b10, 1'b0, 64'hCAFE_F00D_1234_5678, 64'd0);
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        logic [1:0]    sz;
        int unsigned   b;
        for (int i = 0; i < 30; i++) begin
            sel = int'($urandom_range(0, 2));
            sz  = 2'($urandom);
            b   = 1 << sz;
            a   = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~AW'(b - 1);
            run_txn(1'($urandom), a, sz, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
        end
    endtask

    task automatic test_back_to_back();
        int n, nresp, strobes;
        int resp_cyc [3];
        logic [63:0] exp_rd;
        sel = 0;
        n   = wait_of(sel) + 1;
        @(posedge clock); #1;
        rsp_data  = {$urandom, $urandom};
        exp_rd    = exp_load(rsp_data, 2'b10, 1'b1);
        req_write = 1'b0; req_addr = 32'h100; req_size = 2'b10; req_signed = 1'b1;
        req_valid = 1'b1;
        nresp   = 0;
        strobes = 0;
        for (int c = 1; c <= 60 && nresp < 3; c++) begin
            @(negedge clock);
            total++;
            if (c_mr && c_mw) $display("FAIL b2b_overlap: mr=%b mw=%b", c_mr, c_mw);
            else passed++;
            if (c_mr || c_mw || c_rv) begin
                total++;
                if (c_rdy !== 1'b0) $display("FAIL b2b_ready: cyc=%0d got %b want 0", c, c_rdy);
                else passed++;
            end
            if (c_mr) strobes++;
            if (c_rv) begin
                resp_cyc[nresp] = c;
                nresp++;
                total++;
                if ({c_re, c_rd} !== {1'b0, exp_rd})
                    $display("FAIL b2b_rdata: re=%b rd=%h want re=0 rd=%h", c_re, c_rd, exp_rd);
                else passed++;
                if (nresp == 3) req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        total++;
        if (nresp != 3) $display("FAIL b2b_count: got %0d responses want 3", nresp);
        else passed++;
        if (nresp == 3) begin
            total++;
            if ({resp_cyc[1] - resp_cyc[0], resp_cyc[2] - resp_cyc[1], strobes} !== {n + 2, n + 2, 3 * n})
                $display("FAIL b2b_spacing: gaps %0d,%0d strobes %0d want %0d,%0d strobes %0d",
                         resp_cyc[1] - resp_cyc[0], resp_cyc[2] - resp_cyc[1], strobes, n + 2, n + 2, 3 * n);
            else passed++;
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        total++;
        if ({c_rdy, c_mr, c_rv} !== 3'b100)
            $display("FAIL b2b_idle: rdy=%b mr=%b rv=%b want 1,0,0", c_rdy, c_mr, c_rv);
        else passed++;
    endtask

    task automatic test_reset_mid();
        sel = 1;
        @(posedge clock); #1;
        rsp_data  = 64'h5555_AAAA_5555_AAAA;
        req_write = 1'b0; req_addr = 32'h200; req_size = 2'b11; req_signed = 1'b0;
        req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        total++;
        if (c_mr !== 1'b1) $display("FAIL mid_strobe: got %b want 1 in 2nd access cycle", c_mr);
        else passed++;
        reset = 1'b1;
        @(negedge clock);
        total++;
        if ({c_mr, c_mw, c_rv, c_rdy, c_ad, c_sz, c_data} !==
            {1'b0, 1'b0, 1'b0, 1'b1, {AW{1'b0}}, 2'b00, idle_pat})
            $display("FAIL mid_reset: mr=%b mw=%b rv=%b rdy=%b ad=%h sz=%b data=%h",
                     c_mr, c_mw, c_rv, c_rdy, c_ad, c_sz, c_data);
        else passed++;
        @(posedge clock); #1;
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            total++;
            if ({c_rv, c_mr, c_rdy} !== 3'b001)
                $display("FAIL mid_quiet: cyc=%0d rv=%b mr=%b rdy=%b want 0,0,1", c, c_rv, c_mr, c_rdy);
            else passed++;
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_size = 2'b00; req_signed = 1'b0; req_wdata = '0; sel = 0;
        rsp_data = '0; idle_pat = 64'h0F0F_0F0F_0F0F_0F0F;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        test_reset();
        test_store_basic();
        test_load_extend();
        test_misaligned();
        test_wait0();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
